// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU pipeline: M-extension funct3 codes,
// the multiply/divide FSM encoding and the datapath width.
package mini_cpu_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = $clog2(XLEN);

   localparam logic [6:0] MULDIV_FUNCT7 = 7'h01;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } md_state_t;

   // MUL is treated as unsigned: its low product half is sign-agnostic.
   function automatic logic f3_rs1_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic f3_rs2_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/md_negate.sv
// Conditional two's-complement of a W-bit value; purely combinational.
module md_negate #(
   parameter int unsigned W = 32
) (
   input  logic         i_neg,
   input  logic [W-1:0] i_val,
   output logic [W-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, stalling the upstream pipeline while busy.
module ex_muldiv
   import mini_cpu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [4:0]      in_rd_addr,
   input  logic            flush,
   output logic            stall,
   output logic            out_valid,
   output logic [XLEN-1:0] out_result,
   output logic [4:0]      out_rd_addr
);

   md_state_t        r_state;
   md_state_t        w_state_next;
   logic [2:0]       r_funct3;
   logic [4:0]       r_rd;
   logic             r_neg1;
   logic             r_neg2;
   logic [XLEN-1:0]  r_hi;
   logic [XLEN-1:0]  r_lo;
   logic [XLEN-1:0]  r_op;
   logic [XLEN-1:0]  r_result;
   logic [CNT_W-1:0] r_cnt;

   logic              w_accept;
   logic              w_rs1_neg;
   logic              w_rs2_neg;
   logic [XLEN-1:0]   w_rs1_mag;
   logic [XLEN-1:0]   w_rs2_mag;
   logic              w_is_div;
   logic              w_div_zero;
   logic              w_div_ovf;
   logic              w_fast;
   logic [XLEN-1:0]   w_fast_result;
   logic              w_r_is_div;
   logic [XLEN:0]     w_mul_sum;
   logic [XLEN:0]     w_div_shift;
   logic [XLEN:0]     w_div_trial;
   logic              w_div_ok;
   logic [2*XLEN-1:0] w_fix_in;
   logic [2*XLEN-1:0] w_fix_out;
   logic              w_fix_neg;
   logic [XLEN-1:0]   w_fix_result;

   assign w_accept  = (r_state == IDLE) && in_valid && !flush;
   assign w_rs1_neg = f3_rs1_signed(in_funct3) && in_rs1_data[XLEN-1];
   assign w_rs2_neg = f3_rs2_signed(in_funct3) && in_rs2_data[XLEN-1];

   md_negate #(.W(XLEN)) u_neg_rs1 (
      .i_neg (w_rs1_neg),
      .i_val (in_rs1_data),
      .o_val (w_rs1_mag)
   );

   md_negate #(.W(XLEN)) u_neg_rs2 (
      .i_neg (w_rs2_neg),
      .i_val (in_rs2_data),
      .o_val (w_rs2_mag)
   );

   // Cases with an architecturally fixed answer bypass the iteration.
   assign w_is_div   = in_funct3[2];
   assign w_div_zero = w_is_div && (in_rs2_data == '0);
   assign w_div_ovf  = w_is_div && !in_funct3[0]
                       && (in_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                       && (in_rs2_data == '1);
   assign w_fast     = w_div_zero || w_div_ovf;

   always_comb begin
      w_fast_result = '0;
      if (w_div_zero)
         w_fast_result = in_funct3[1] ? in_rs1_data : '1;
      else
         w_fast_result = in_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   assign w_r_is_div = r_funct3[2];

   assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : '0);
   assign w_div_shift = {r_hi, r_lo[XLEN-1]};
   assign w_div_trial = w_div_shift - {1'b0, r_op};
   assign w_div_ok    = !w_div_trial[XLEN];

   // One shared 64-bit negator handles product, quotient and remainder.
   always_comb begin
      w_fix_in  = {r_hi, r_lo};
      w_fix_neg = r_neg1 ^ r_neg2;
      if (w_r_is_div) begin
         if (r_funct3[1]) begin
            w_fix_in  = {{XLEN{1'b0}}, r_hi};
            w_fix_neg = r_neg1;
         end else begin
            w_fix_in  = {{XLEN{1'b0}}, r_lo};
         end
      end
   end

   md_negate #(.W(2*XLEN)) u_neg_fix (
      .i_neg (w_fix_neg),
      .i_val (w_fix_in),
      .o_val (w_fix_out)
   );

   assign w_fix_result = (!w_r_is_div && (r_funct3 != F3_MUL)) ?
                         w_fix_out[2*XLEN-1:XLEN] : w_fix_out[XLEN-1:0];

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (flush) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE: if (in_valid) w_state_next = w_fast ? DONE : CALC;
            CALC: if (r_cnt == '0) w_state_next = FIX;
            FIX:  w_state_next = DONE;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_funct3 <= '0;
         r_rd     <= '0;
         r_neg1   <= 1'b0;
         r_neg2   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_op     <= '0;
         r_result <= '0;
         r_cnt    <= '0;
      end else if (!flush) begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_funct3 <= in_funct3;
                  r_rd     <= in_rd_addr;
                  r_neg1   <= w_rs1_neg;
                  r_neg2   <= w_rs2_neg;
                  r_cnt    <= CNT_W'(XLEN - 1);
                  r_hi     <= '0;
                  r_lo     <= w_is_div ? w_rs1_mag : w_rs2_mag;
                  r_op     <= w_is_div ? w_rs2_mag : w_rs1_mag;
                  if (w_fast)
                     r_result <= w_fast_result;
               end
            end
            CALC: begin
               r_cnt <= r_cnt - 1'b1;
               // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
               if (w_r_is_div) begin
                  r_hi <= w_div_ok ? w_div_trial[XLEN-1:0] : w_div_shift[XLEN-1:0];
                  r_lo <= {r_lo[XLEN-2:0], w_div_ok};
               end else begin
                  r_hi <= w_mul_sum[XLEN:1];
                  r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
               end
            end
            FIX: r_result <= w_fix_result;
            default: ;
         endcase
      end
   end

   assign stall       = w_accept || (r_state == CALC) || (r_state == FIX);
   assign out_valid   = (r_state == DONE);
   assign out_result  = (r_state == DONE) ? r_result : '0;
   assign out_rd_addr = (r_state == DONE) ? r_rd : '0;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: results, latency, stall length,
// fast paths, flush and mid-operation reset.
module tb_ex_muldiv;
   import mini_cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [2:0]  in_funct3;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic [4:0]  in_rd_addr;
   logic        flush;
   logic        stall;
   logic        out_valid;
   logic [31:0] out_result;
   logic [4:0]  out_rd_addr;

   int n_tests = 0;
   int n_fail  = 0;

   ex_muldiv dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_funct3   (in_funct3),
      .in_rs1_data (in_rs1_data),
      .in_rs2_data (in_rs2_data),
      .in_rd_addr  (in_rd_addr),
      .flush       (flush),
      .stall       (stall),
      .out_valid   (out_valid),
      .out_result  (out_result),
      .out_rd_addr (out_rd_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
      in_valid    = 1'b1;
      in_funct3   = f3;
      in_rs1_data = a;
      in_rs2_data = b;
      in_rd_addr  = rd;
   endtask

   // Issue in the current IDLE cycle, wait for the result, return in the next IDLE cycle.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_lat);
      int lat;
      int stalls;
      drive_op(f3, a, b, rd);
      #1;
      stalls = stall ? 1 : 0;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         if (stall) stalls++;
         step();
         lat++;
      end
      if (!out_valid) begin
         check({tag, " timeout"}, 32'(out_valid), 32'd1);
      end else begin
         check({tag, " result"}, out_result, exp_res);
         check({tag, " rd"}, 32'(out_rd_addr), 32'(rd));
         check({tag, " latency"}, 32'(lat), 32'(exp_lat));
         check({tag, " stall cycles"}, 32'(stalls), 32'(exp_lat));
         check({tag, " stall in done"}, 32'(stall), 32'd0);
      end
      step();
      check({tag, " single pulse"}, 32'(out_valid), 32'd0);
   endtask

   task automatic watch_no_valid(input string tag, input int cycles);
      int pulses;
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         if (out_valid) pulses++;
         step();
      end
      check({tag, " no out_valid"}, 32'(pulses), 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_funct3   = '0;
      in_rs1_data = '0;
      in_rs2_data = '0;
      in_rd_addr  = '0;
      flush       = 1'b0;
      step();
      step();
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_result", out_result, 32'd0);
      check("reset out_rd_addr", 32'(out_rd_addr), 32'd0);
      check("reset stall", 32'(stall), 32'd0);
      reset = 1'b0;
      step();

      run_op("MUL 7*-3",        F3_MUL,    32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34);
      run_op("MULH min*min",    F3_MULH,   32'h80000000,   32'h80000000, 5'd6,  32'h40000000, 34);
      run_op("MULHU max*max",   F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 34);
      run_op("MULHSU -1*max",   F3_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 34);
      run_op("DIV -7/2",        F3_DIV,    32'hFFFFFFF9,   32'd2,        5'd9,  32'hFFFFFFFD, 34);
      run_op("REM -7/2",        F3_REM,    32'hFFFFFFF9,   32'd2,        5'd10, 32'hFFFFFFFF, 34);
      run_op("DIVU 100/7",      F3_DIVU,   32'd100,        32'd7,        5'd11, 32'd14,       34);
      run_op("REMU 100/7",      F3_REMU,   32'd100,        32'd7,        5'd12, 32'd2,        34);
      run_op("DIV 5/0",         F3_DIV,    32'd5,          32'd0,        5'd13, 32'hFFFFFFFF, 1);
      run_op("REM 5/0",         F3_REM,    32'd5,          32'd0,        5'd14, 32'd5,        1);
      run_op("DIV ovf",         F3_DIV,    32'h80000000,   32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
      run_op("REM ovf",         F3_REM,    32'h80000000,   32'hFFFFFFFF, 5'd16, 32'd0,        1);

      // flush at T+10 of a multiply
      drive_op(F3_MUL, 32'd1234, 32'd5678, 5'd20);
      step();
      in_valid = 1'b0;
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush stall", 32'(stall), 32'd0);
      watch_no_valid("flush", 40);
      run_op("DIVU 9/3 after flush", F3_DIVU, 32'd9, 32'd3, 5'd21, 32'd3, 34);

      // simultaneous flush and in_valid in IDLE
      drive_op(F3_MUL, 32'd2, 32'd3, 5'd22);
      flush = 1'b1;
      #1;
      check("flush+valid stall", 32'(stall), 32'd0);
      step();
      in_valid = 1'b0;
      flush    = 1'b0;
      check("flush+valid not accepted", 32'(stall), 32'd0);
      watch_no_valid("flush+valid", 40);

      // reset at T+5 of a divide
      drive_op(F3_DIV, 32'd1000, 32'd3, 5'd23);
      step();
      in_valid = 1'b0;
      repeat (4) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midreset out_valid", 32'(out_valid), 32'd0);
      check("midreset out_result", out_result, 32'd0);
      check("midreset out_rd_addr", 32'(out_rd_addr), 32'd0);
      check("midreset stall", 32'(stall), 32'd0);
      watch_no_valid("midreset", 40);

      run_op("MUL 3*4 b2b", F3_MUL, 32'd3, 32'd4, 5'd24, 32'd12, 34);
      run_op("MUL 5*6 b2b", F3_MUL, 32'd5, 32'd6, 5'd25, 32'd30, 34);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the execute stage of the mini CPU pipeline, directly downstream of the ID/EX pipeline register. It consumes the registered operands, funct3 and rd address of an M-extension instruction and produces a 32-bit result after a multi-cycle shift-add or restoring-divide sequence. While busy it asserts `stall` to freeze the ID/EX register and upstream stages.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported. The iteration counter is clog2(XLEN) bits wide.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the ID/EX entry is an M-extension R-type instruction (funct7 = 7'h01, decoded upstream).
- `in_funct3`  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `in_rs1_data`  in  32  dividend / multiplicand.
- `in_rs2_data`  in  32  divisor / multiplier.
- `in_rd_addr`  in  5  destination register.
- `flush`  in  1  kill the in-flight operation.
- `stall`  out  1  hold ID/EX and all upstream stages.
- `out_valid`  out  1  one-cycle result strobe.
- `out_result`  out  32  result; valid only while `out_valid` is high.
- `out_rd_addr`  out  5  rd of the completing operation.

## Operation
- States:
  - IDLE: wait for work.
  - CALC: XLEN iterations.
  - FIX: apply sign correction and select the output.
  - DONE: present the result.
- IDLE with `in_valid` and no `flush`:
  - Latch funct3 and rd.
  - Latch operand magnitudes and sign flags. Signed operands are MULH (both), MULHSU (rs1 only), DIV/REM (both); all other cases are unsigned.
  - Load the counter with XLEN-1. Go to CALC.
- Fast path (IDLE → DONE, skipping CALC/FIX):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC, multiply (one step per cycle):
  - 64-bit accumulator {hi, lo}, with lo initialised to the multiplier magnitude.
  - If lo[0] is set, hi += multiplicand, using a 33-bit sum.
  - Shift {carry, hi, lo} right by one.
- CALC, divide (one step per cycle):
  - Restoring division with a 33-bit partial remainder.
  - Shift in the next dividend bit, trial-subtract the divisor, and keep the result if it is non-negative.
  - The quotient bit enters the LSB.
- Counter: decrements each CALC cycle. Counter = 0 in CALC → FIX.
- FIX:
  - Multiply: negate the 64-bit product if the operand signs differ. MUL selects the low 32 bits; MULH/MULHSU/MULHU select the high 32 bits.
  - Divide: negate the quotient if the signs differ. The remainder takes the dividend's sign.
  - Register the result. Go to DONE.
- DONE: `out_valid` = 1 for one cycle, `out_result` and `out_rd_addr` are driven, then → IDLE unconditionally. `in_valid` is not sampled in DONE.
- `stall` = (IDLE & `in_valid` & !`flush`) | CALC | FIX. It is low in DONE, so ID/EX advances on the edge that leaves DONE.
- `flush` in any state → IDLE on the next edge. `out_valid` stays 0 and no result is produced. `flush` has priority over `in_valid`.
- `reset` → IDLE. Reset values: `out_valid` 0, `out_result` 0, `out_rd_addr` 0, `stall` 0, all internal registers 0.

## Timing
- Acceptance edge is T (IDLE → CALC).
- CALC covers T+1 … T+32 (32 edges). FIX is the cycle after T+32. DONE (`out_valid` high) is cycle T+34.
- `stall` is high from the cycle in which `in_valid` is first seen until DONE.
- Fast path: `out_valid` is high in cycle T+1. `stall` is high only in the acceptance cycle.
- Back-to-back M instructions: the second is accepted in the IDLE cycle immediately after DONE, so there are 0 idle bubbles beyond the IDLE cycle itself.
- Simultaneous `flush` and `in_valid` in IDLE: the operation is not accepted and `stall` = 0.
- Reset mid-CALC: the block is in IDLE with all outputs 0 on the next edge.

## Structure
- Shared package `mini_cpu_pkg` holds:
  - the funct3 constants (MUL…REMU);
  - the `MULDIV_FUNCT7` constant 7'h01;
  - the `md_state_t` enum (IDLE, CALC, FIX, DONE);
  - XLEN.
- One sub-module is natural: `md_negate`, a combinational conditional two's-complement of a width-parameterised value. It is used for the operand magnitudes (32 bits) and the FIX correction (64 bits).
- All remaining logic (FSM, counter, datapath) sits in `ex_muldiv`.

## Test plan
- MUL 7 × 0xFFFFFFFD → `out_result` 0xFFFFFFEB and `out_rd_addr` = the issued rd, with `out_valid` at T+34 and `stall` high for exactly 34 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0. All four give `out_valid` at T+1.
- MUL issued, `flush` at T+10 → IDLE next edge, `stall` 0, no `out_valid`; a following DIVU 9 / 3 → 3 completes normally.
- `reset` pulsed at T+5 of a DIV → all outputs 0, IDLE. Then two back-to-back MULs (3×4, 5×6) → 12 and 30, each with one `out_valid` pulse and the correct rd.
